// File: rtl/bin_to_dec_if.sv
// Handshake and divider bundle for bin_to_dec: conversion request/result plus the n/d/start and q/r/rdy divider link.
// The slave modport faces the converter; the master modport faces the requester and the divider.
interface bin_to_dec_if #(
  parameter int BITS   = 32,
  parameter int DIGITS = 10
);
  localparam int NDW = $clog2(DIGITS + 1);

  logic [BITS-1:0]     value;
  logic                start;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] digits;
  logic [NDW-1:0]      ndigits;
  logic                neg;
  logic                ovf;
  logic [BITS-1:0]     div_n;
  logic [BITS-1:0]     div_d;
  logic                div_start;
  logic [BITS-1:0]     div_q;
  logic [BITS-1:0]     div_r;
  logic                div_rdy;

  modport master (
    output value, start, div_q, div_r, div_rdy,
    input  busy, done, digits, ndigits, neg, ovf, div_n, div_d, div_start
  );

  modport slave (
    input  value, start, div_q, div_r, div_rdy,
    output busy, done, digits, ndigits, neg, ovf, div_n, div_d, div_start
  );
endinterface

// File: rtl/bin_to_dec.sv
// Binary to packed BCD, one external divide-by-10 per digit, least-significant digit first.
// Optional BIN_TO_DEC_SIGNED_EN treats value as two's complement and reports the sign on neg.
module bin_to_dec #(
  parameter int BITS   = 32,
  parameter int DIGITS = 10
) (
  input logic         clk,
  input logic         rst,
  bin_to_dec_if.slave bus
);
  localparam int NDW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [BITS-1:0]     r_v;
  logic [4*DIGITS-1:0] r_digits;
  logic [NDW-1:0]      r_ndigits;
  logic                r_neg;
  logic                r_ovf;
  logic                r_done;
  logic                r_busy;
  logic                r_div_start;

  logic                w_neg;
  logic [BITS-1:0]     w_mag;
  logic [NDW-1:0]      w_nd_inc;
  logic                w_unused_r;

`ifdef BIN_TO_DEC_SIGNED_EN
  // Most-negative input negates to itself, which is the correct unsigned magnitude.
  assign w_neg = bus.value[BITS-1];
  assign w_mag = w_neg ? (BITS'(0) - bus.value) : bus.value;
`else
  assign w_neg = 1'b0;
  assign w_mag = bus.value;
`endif

  assign w_nd_inc   = r_ndigits + NDW'(1);
  assign w_unused_r = ^bus.div_r[BITS-1:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_v         <= '0;
      r_digits    <= '0;
      r_ndigits   <= '0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_div_start <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_v         <= w_mag;
            r_neg       <= w_neg;
            r_digits    <= '0;
            r_ndigits   <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b1;
            r_div_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // The divider drops rdy on its load edge, so any rdy seen here is fresh.
          if (bus.div_rdy) begin
            for (int k = 0; k < DIGITS; k++) begin
              if (r_ndigits == NDW'(k)) begin
                r_digits[4*k +: 4] <= bus.div_r[3:0];
              end
            end
            r_ndigits <= w_nd_inc;
            r_v       <= bus.div_q;
            if (bus.div_q == '0) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_nd_inc == NDW'(DIGITS)) begin
              r_ovf   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_div_start <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.digits    = r_digits;
  assign bus.ndigits   = r_ndigits;
  assign bus.neg       = r_neg;
  assign bus.ovf       = r_ovf;
  assign bus.div_n     = r_v;
  assign bus.div_d     = BITS'(10);
  assign bus.div_start = r_div_start;
endmodule

// File: tb/tb_bin_to_dec.sv
// Bench for bin_to_dec: two converters (10 and 4 digit slots), each wired to a restoring shift-subtract divider.
module tb_bin_to_dec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div_rst = 1'b1;
  always #5 clk = ~clk;

  bin_to_dec_if #(.BITS(32), .DIGITS(10)) bus0 ();
  bin_to_dec_if #(.BITS(32), .DIGITS(4))  bus4 ();

  bin_to_dec #(.BITS(32), .DIGITS(10)) u_dut  (.clk(clk), .rst(rst), .bus(bus0));
  bin_to_dec #(.BITS(32), .DIGITS(4))  u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  logic        sel = 1'b0;
  logic        start_r = 1'b0;
  logic [31:0] value_r = '0;

  assign bus0.value = value_r;
  assign bus4.value = value_r;
  assign bus0.start = start_r && !sel;
  assign bus4.start = start_r && sel;

  // Sequential divider: loads on start, BITS shift-subtract steps, rdy after the last step.
  logic        dv_start [2];
  logic [31:0] dv_n     [2];
  logic [31:0] dv_d     [2];
  logic [31:0] dv_dl    [2];
  logic [31:0] dv_quo   [2];
  logic [31:0] dv_rem   [2];
  logic [5:0]  dv_cnt   [2];
  logic        dv_rdy   [2];

  assign dv_start[0] = bus0.div_start;
  assign dv_start[1] = bus4.div_start;
  assign dv_n[0]     = bus0.div_n;
  assign dv_n[1]     = bus4.div_n;
  assign dv_d[0]     = bus0.div_d;
  assign dv_d[1]     = bus4.div_d;
  assign bus0.div_q   = dv_quo[0];
  assign bus0.div_r   = dv_rem[0];
  assign bus0.div_rdy = dv_rdy[0];
  assign bus4.div_q   = dv_quo[1];
  assign bus4.div_r   = dv_rem[1];
  assign bus4.div_rdy = dv_rdy[1];

  function automatic logic [32:0] div_step(input logic [31:0] rem, input logic msb, input logic [31:0] d);
    logic [32:0] t;
    t = {rem, msb};
    if (t >= {1'b0, d}) return {1'b1, 32'(t - {1'b0, d})};
    return {1'b0, t[31:0]};
  endfunction

  always @(posedge clk or posedge div_rst) begin
    if (div_rst) begin
      for (int i = 0; i < 2; i++) begin
        dv_quo[i] <= '0; dv_rem[i] <= '0; dv_cnt[i] <= '0; dv_rdy[i] <= 1'b0; dv_dl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (dv_start[i]) begin
          dv_quo[i] <= dv_n[i];
          dv_rem[i] <= '0;
          dv_dl[i]  <= dv_d[i];
          dv_cnt[i] <= 6'd32;
          dv_rdy[i] <= 1'b0;
        end else if (dv_cnt[i] != 6'd0) begin
          dv_rem[i] <= div_step(dv_rem[i], dv_quo[i][31], dv_dl[i])[31:0];
          dv_quo[i] <= {dv_quo[i][30:0], div_step(dv_rem[i], dv_quo[i][31], dv_dl[i])[32]};
          dv_cnt[i] <= dv_cnt[i] - 6'd1;
          if (dv_cnt[i] == 6'd1) dv_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Observation mux onto whichever converter is selected.
  logic        m_busy, m_done, m_neg, m_ovf, m_div_start;
  logic [39:0] m_digits;
  logic [3:0]  m_ndigits;
  logic [31:0] m_div_n, m_div_d;
  assign m_busy      = sel ? bus4.busy : bus0.busy;
  assign m_done      = sel ? bus4.done : bus0.done;
  assign m_neg       = sel ? bus4.neg : bus0.neg;
  assign m_ovf       = sel ? bus4.ovf : bus0.ovf;
  assign m_div_start = sel ? bus4.div_start : bus0.div_start;
  assign m_digits    = sel ? {24'h0, bus4.digits} : bus0.digits;
  assign m_ndigits   = sel ? {1'b0, bus4.ndigits} : bus0.ndigits;
  assign m_div_n     = sel ? bus4.div_n : bus0.div_n;
  assign m_div_d     = sel ? bus4.div_d : bus0.div_d;

  typedef struct {
    logic [39:0] digits;
    int          ndigits;
    logic        neg;
    logic        ovf;
    logic [31:0] mag;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [39:0] d, input int n, input logic ng, input logic o, input logic [31:0] mag);
    exp_t e;
    e.digits = d; e.ndigits = n; e.neg = ng; e.ovf = o; e.mag = mag; e.lat = 34 * n;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] val, input int nd);
    exp_t e;
    logic [31:0] m;
    m = val;
    e.neg = 1'b0;
`ifdef BIN_TO_DEC_SIGNED_EN
    if (val[31]) begin
      e.neg = 1'b1;
      m = 32'd0 - val;
    end
`endif
    e.mag = m; e.digits = '0; e.ndigits = 0;
    for (int k = 0; k < nd; k++) begin
      e.digits[4*k +: 4] = 4'(m % 10);
      m = m / 10;
      e.ndigits++;
      if (m == 0) break;
    end
    e.ovf = (m != 0);
    e.lat = 34 * e.ndigits;
    return e;
  endfunction

  // One conversion: push expectation, start, wait for done (bounded), pop and compare.
  task automatic convert(input logic s, input logic [31:0] val, input exp_t e, input int inj);
    int   c;
    int   starts;
    exp_t x;
    sel = s;
    value_r = val;
    sb.push_back(e);
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    chk("busy_after_start", 64'(m_busy), 64'(1));
    chk("div_start_issue", 64'(m_div_start), 64'(1));
    chk("div_n_issue", 64'(m_div_n), 64'(e.mag));
    chk("div_d_ten", 64'(m_div_d), 64'(10));
    starts = 1;
    c = 0;
    while (!m_done && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (inj > 0) begin
        start_r = (c == inj);
        if (c == inj) value_r = ~val;
      end
      if (m_div_start) starts++;
    end
    start_r = 1'b0;
    x = sb.pop_front();
    chk("done_latency", 64'(c), 64'(x.lat));
    chk("digits", 64'(m_digits), 64'(x.digits));
    chk("ndigits", 64'(m_ndigits), 64'(x.ndigits));
    chk("neg", 64'(m_neg), 64'(x.neg));
    chk("ovf", 64'(m_ovf), 64'(x.ovf));
    chk("div_start_pulses", 64'(starts), 64'(x.ndigits));
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(m_done), 64'(0));
    chk("idle_after_done", 64'(m_busy), 64'(0));
    chk("digits_hold", 64'(m_digits), 64'(x.digits));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus0.busy), 64'(0));
    chk("rst_done", 64'(bus0.done), 64'(0));
    chk("rst_div_start", 64'(bus0.div_start), 64'(0));
    chk("rst_digits", 64'(bus0.digits), 64'(0));
    chk("rst_ndigits", 64'(bus0.ndigits), 64'(0));
    chk("rst_neg_ovf", 64'({bus0.neg, bus0.ovf}), 64'(0));
    rst = 1'b0;
    div_rst = 1'b0;

    convert(1'b0, 32'd0, mk(40'h0, 1, 1'b0, 1'b0, 32'd0), 0);
    convert(1'b0, 32'd12345, mk(40'h12345, 5, 1'b0, 1'b0, 32'd12345), 0);
`ifdef BIN_TO_DEC_SIGNED_EN
    convert(1'b0, 32'hFFFFFFFF, mk(40'h1, 1, 1'b1, 1'b0, 32'd1), 0);
    convert(1'b0, 32'h80000000, mk(40'h2147483648, 10, 1'b1, 1'b0, 32'h80000000), 0);
`else
    convert(1'b0, 32'hFFFFFFFF, mk(40'h4294967295, 10, 1'b0, 1'b0, 32'hFFFFFFFF), 0);
    convert(1'b0, 32'h80000000, mk(40'h2147483648, 10, 1'b0, 1'b0, 32'h80000000), 0);
`endif
    convert(1'b1, 32'd12345, mk(40'h2345, 4, 1'b0, 1'b1, 32'd12345), 0);
    convert(1'b0, 32'd987654, mk(40'h987654, 6, 1'b0, 1'b0, 32'd987654), 60);

    for (int i = 0; i < 3; i++) begin
      logic [31:0] v;
      v = $urandom;
      convert(1'b0, v, model(v, 10), 0);
      convert(1'b1, v, model(v, 4), 0);
    end

    // Reset in the middle of a divide, then a clean conversion.
    sel = 1'b0;
    value_r = 32'd12345;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus0.busy), 64'(0));
    chk("midrst_div_start", 64'(bus0.div_start), 64'(0));
    chk("midrst_outputs", 64'({bus0.done, bus0.neg, bus0.ovf, bus0.ndigits}), 64'(0));
    chk("midrst_digits", 64'(bus0.digits), 64'(0));
    #2;
    rst = 1'b0;
    convert(1'b0, 32'd42, mk(40'h42, 2, 1'b0, 1'b0, 32'd42), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
